// File: rtl/aes_pkg.sv
// Shared definitions for the byte-serial AES state datapath blocks.
package aes_pkg;

  localparam int DATA_W_DEF = 8;

  // One element of the AES/Rijndael state at the default width.
  typedef logic [DATA_W_DEF-1:0] state_byte_t;

  // Rijndael allows 4, 6 or 8 state columns.
  function automatic bit nb_is_legal(input int nb);
    return (nb == 4) || (nb == 6) || (nb == 8);
  endfunction

  // Cyclic column shift applied to each row. Only the 8-column state differs,
  // where rows 2 and 3 move one extra column.
  function automatic logic [2:0] srow_offset(input int nb, input logic [1:0] row);
    if (nb == 8 && row[1]) begin
      return {1'b0, row} + 3'd1;
    end
    return {1'b0, row};
  endfunction

endpackage

// File: rtl/shiftrows_src_index.sv
// Maps an output position k = r + 4*c to the buffer position holding the
// byte that belongs there, for either the forward or the inverse permutation.
module shiftrows_src_index
  import aes_pkg::*;
#(
  parameter int NB    = 4,
  parameter int IDX_W = $clog2(4 * NB)
) (
  input  logic [IDX_W-1:0] i_rd_idx,
  input  logic             i_inv,
  output logic [IDX_W-1:0] o_src_idx
);

  // Column field width, and one extra bit so col + NB never overflows.
  localparam int CW = IDX_W - 2;
  localparam int SW = IDX_W - 1;

  logic [1:0]    w_row;
  logic [CW-1:0] w_col;
  logic [2:0]    w_shift;
  logic [SW-1:0] w_sum;
  logic [CW-1:0] w_col_src;

  // Column rotation with an explicit wrap so NB=6 stays correct.
  always_comb begin
    w_row   = i_rd_idx[1:0];
    w_col   = i_rd_idx[IDX_W-1:2];
    w_shift = srow_offset(NB, w_row);
    if (i_inv) begin
      w_sum = SW'(w_col) + SW'(NB) - SW'(w_shift);
    end else begin
      w_sum = SW'(w_col) + SW'(w_shift);
    end
    if (w_sum >= SW'(NB)) begin
      w_col_src = CW'(w_sum - SW'(NB));
    end else begin
      w_col_src = CW'(w_sum);
    end
    o_src_idx = {w_col_src, w_row};
  end

endmodule

// File: rtl/shiftrows_stream.sv
// Byte-serial (Inv)ShiftRows. A block of 4*NB bytes is written in arrival
// order into one bank of a ping-pong buffer while the other bank is read out
// in permuted order, so the stream runs at one byte per cycle.
module shiftrows_stream
  import aes_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NB     = 4
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_inv,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              out_inv
);

  localparam int N     = 4 * NB;
  localparam int IDX_W = $clog2(N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam bit NB_OK = nb_is_legal(NB);

  if (!NB_OK) begin : g_bad_nb
    $error("shiftrows_stream: NB must be 4, 6 or 8");
  end

  logic [DATA_W-1:0] r_mem [2][N];
  logic              r_wr_bank;
  logic              r_rd_bank;
  logic [IDX_W-1:0]  r_wr_idx;
  logic [IDX_W-1:0]  r_rd_idx;
  logic [1:0]        r_full;
  logic [1:0]        r_inv;

  logic              w_in_fire;
  logic              w_out_fire;
  logic [IDX_W-1:0]  w_src_idx;

  // Handshake depends only on registered bank flags; resetn just masks them
  // during the reset cycle itself.
  assign in_ready   = resetn & ~r_full[r_wr_bank];
  assign out_valid  = resetn & r_full[r_rd_bank];
  assign out_last   = out_valid & (r_rd_idx == LAST_IDX);
  assign out_inv    = resetn & r_inv[r_rd_bank];
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;

  shiftrows_src_index #(
    .NB    (NB),
    .IDX_W (IDX_W)
  ) u_src_index (
    .i_rd_idx  (r_rd_idx),
    .i_inv     (r_inv[r_rd_bank]),
    .o_src_idx (w_src_idx)
  );

  // The read bank is never written while full, so this holds steady under stall.
  assign out_data = out_valid ? r_mem[r_rd_bank][w_src_idx] : '0;

  // Byte storage; contents are meaningless until a bank is marked full.
  always_ff @(posedge clock) begin
    if (w_in_fire) begin
      r_mem[r_wr_bank][r_wr_idx] <= in_data;
    end
  end

  // Write and read pointers, bank flags and per-bank mode bits. A fill and a
  // drain completing together always touch different banks.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
      r_wr_idx  <= '0;
      r_rd_idx  <= '0;
      r_full    <= 2'b00;
      r_inv     <= 2'b00;
    end else begin
      if (w_in_fire) begin
        if (r_wr_idx == '0) begin
          r_inv[r_wr_bank] <= in_inv;
        end
        if (r_wr_idx == LAST_IDX) begin
          r_full[r_wr_bank] <= 1'b1;
          r_wr_bank         <= ~r_wr_bank;
          r_wr_idx          <= '0;
        end else begin
          r_wr_idx <= r_wr_idx + 1'b1;
        end
      end
      if (w_out_fire) begin
        if (r_rd_idx == LAST_IDX) begin
          r_full[r_rd_bank] <= 1'b0;
          r_rd_bank         <= ~r_rd_bank;
          r_rd_idx          <= '0;
        end else begin
          r_rd_idx <= r_rd_idx + 1'b1;
        end
      end
    end
  end

endmodule
